enm_hp_ctrl: RTL and testbench
==============================

ENM_HP_CTRL -- requirements
Module: enm_hp_ctrl

Interface
REQ-001 The block SHALL have parameter HP_INIT, default 100, meaning the per-enemy starting HP (7-bit, 1..127).
REQ-002 The block SHALL have parameter IFRAMES, default 8, meaning invulnerability length in clk22 cycles after a non-lethal hit (1..255).
REQ-003 The block SHALL have parameter REGEN_PERIOD, default 64, meaning the clk22 cycles between regeneration ticks (2..65535).
REQ-004 clk22  input  1  clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 hit  input  4  per-enemy hit strobe from collision logic; bit i = enemy i+1, sampled every cycle.
REQ-007 dmg  input  3  damage applied per asserted hit bit, shared by all bits in that cycle.
REQ-008 enmhp1..enmhp4  output  7 each  registered HP of enemies 1..4, consumed by the enemy-motion stage.
REQ-009 alive  output  4  bit i high while enemy i+1 is not DEAD.
REQ-010 flash  output  4  bit i high while enemy i+1 is in IFRAME (sprite blink).
REQ-011 all_dead  output  1  high when all four enemies are DEAD.
REQ-012 kill_cnt  output  8  count of enemy deaths since reset.

Function
REQ-013 Each enemy SHALL run an independent FSM with states ALIVE, IFRAME, DEAD.
REQ-014 ALIVE with hit[i]=1 and dmg>0: hp <= max(hp-dmg, 0) on the next edge; result 0 -> DEAD, else -> IFRAME with counter loaded to IFRAMES.
REQ-015 Hits with dmg=0 SHALL be ignored: no HP change, no state change.
REQ-016 IFRAME: hit[i] ignored; counter decrements each cycle; on the cycle the counter equals 1 the state SHALL return to ALIVE (IFRAME lasts exactly IFRAMES cycles).
REQ-017 DEAD SHALL be absorbing until rst; hp held at 0; hits ignored.
REQ-018 Subtraction SHALL be done at 8 bits or wider so that dmg > hp saturates to 0 with no wrap-around.
REQ-019 Simultaneous hits on different enemies SHALL be processed in the same cycle, independently.
REQ-020 kill_cnt SHALL increment by the number of enemies entering DEAD in that cycle (0..4), saturating at 255.
REQ-021 alive, flash, all_dead SHALL be decoded from registered FSM state, so they change on the same edge as the corresponding enmhp value.
REQ-022 Hit-to-HP latency SHALL be exactly one clk22 cycle.

Reset
REQ-023 On rst all enmhpN SHALL be HP_INIT, every FSM in ALIVE, IFRAME counters 0, alive=4'hF, flash=0, all_dead=0, kill_cnt=0, regen timer 0.
REQ-024 rst SHALL take priority over hit in the same cycle, including mid-IFRAME and in DEAD.

Configuration
REQ-025 Macro ENM_HP_REGEN_EN: when defined, a free-running timer SHALL produce a one-cycle tick every REGEN_PERIOD cycles, and on a tick each ALIVE enemy with 0<hp<HP_INIT SHALL gain 1 HP.
REQ-026 With ENM_HP_REGEN_EN defined, a hit and a tick on the same enemy in the same cycle: the hit SHALL win and the tick SHALL be dropped for that enemy; IFRAME and DEAD enemies never regenerate.
REQ-027 Without ENM_HP_REGEN_EN, no timer SHALL be synthesised and HP SHALL never increase except by rst.

Structure
REQ-028 Shared package enm_pkg SHALL hold the HP width constant (7), the FSM state enum, and the HP_INIT/IFRAMES defaults, reused by the enemy-motion stage's thresholds.
REQ-029 Per-enemy logic SHALL be a sub-module enm_hp_unit (FSM, HP register, IFRAME counter, regen-tick input), instantiated four times; the top holds the regen timer, kill counter and decodes.

Verification
REQ-030 rst, then hit=4'b0001, dmg=5 for one cycle -> next cycle enmhp1=95, flash=4'b0001, other HP 100; flash clears exactly 8 cycles later.
REQ-031 hit[1] held high 20 cycles, dmg=7 -> enmhp2 steps 100,93 (IFRAME 8 cycles),86,79,... one decrement per 9 cycles.
REQ-032 enmhp3=3, hit=4'b0100, dmg=7 -> enmhp3=0, alive[2]=0, kill_cnt +1, later hits ignored.
REQ-033 All four at hp 2, hit=4'hF, dmg=4 -> all enmhp=0, all_dead=1, kill_cnt=4 on the same edge.
REQ-034 rst asserted during IFRAME and with two enemies DEAD -> all HP 100, alive=4'hF, flash=0, kill_cnt=0 next cycle.
REQ-035 ENM_HP_REGEN_EN defined, enmhp1=90 idle 128 cycles -> 92; hit on the tick cycle -> decrement only, no +1.

Source files
------------

// File: rtl/enm_pkg.sv
// Shared enemy-HP definitions: HP width, FSM state encoding and default tuning values.
// Also used by the enemy-motion stage for its HP thresholds.
package enm_pkg;

  localparam int HP_W             = 7;
  localparam int HP_INIT_DEF      = 100;
  localparam int IFRAMES_DEF      = 8;
  localparam int REGEN_PERIOD_DEF = 64;

  typedef enum logic [1:0] {
    ENM_ALIVE  = 2'd0,
    ENM_IFRAME = 2'd1,
    ENM_DEAD   = 2'd2
  } enm_state_t;

  // Subtract at 8 bits so that damage larger than the remaining HP clamps to 0
  function automatic logic [HP_W-1:0] hp_sub_sat(input logic [HP_W-1:0] hp, input logic [2:0] dmg);
    logic [7:0] diff;
    diff = {1'b0, hp} - {5'b00000, dmg};
    if (diff[7]) begin
      hp_sub_sat = 7'd0;
    end else begin
      hp_sub_sat = diff[HP_W-1:0];
    end
  endfunction

endpackage

// File: rtl/enm_hp_unit.sv
// Per-enemy HP tracker: ALIVE/IFRAME/DEAD FSM, HP register, invulnerability counter
// and optional regeneration on an externally supplied tick.
module enm_hp_unit
  import enm_pkg::*;
#(
  parameter int HP_INIT = HP_INIT_DEF,
  parameter int IFRAMES = IFRAMES_DEF
) (
  input  logic            clk22,
  input  logic            rst,
  input  logic            hit,
  input  logic [2:0]      dmg,
  input  logic            regen_tick,
  output logic [HP_W-1:0] hp,
  output logic            alive,
  output logic            flash,
  output logic            dying
);

  localparam logic [HP_W-1:0] HP_RST   = HP_W'(HP_INIT);
  localparam logic [7:0]      IFR_LOAD = 8'(IFRAMES);

  enm_state_t      state_r;
  enm_state_t      state_n_s;
  logic [HP_W-1:0] hp_r;
  logic [HP_W-1:0] hp_n_s;
  logic [HP_W-1:0] hp_sub_s;
  logic [7:0]      cnt_r;
  logic [7:0]      cnt_n_s;
  logic            dying_s;

  // Next-state, next-HP and IFRAME counter decode
  always_comb begin
    state_n_s = state_r;
    hp_n_s    = hp_r;
    cnt_n_s   = cnt_r;
    dying_s   = 1'b0;
    hp_sub_s  = hp_sub_sat(hp_r, dmg);
    case (state_r)
      ENM_ALIVE: begin
        if (hit && (dmg != 3'd0)) begin
          hp_n_s = hp_sub_s;
          if (hp_sub_s == 7'd0) begin
            state_n_s = ENM_DEAD;
            cnt_n_s   = 8'd0;
            dying_s   = 1'b1;
          end else begin
            state_n_s = ENM_IFRAME;
            cnt_n_s   = IFR_LOAD;
          end
        end else if (regen_tick && (hp_r != 7'd0) && (hp_r < HP_RST)) begin
          // A hit in the same cycle takes the branch above, so the tick is dropped
          hp_n_s = hp_r + 7'd1;
        end else begin
          hp_n_s = hp_r;
        end
      end
      ENM_IFRAME: begin
        if (cnt_r <= 8'd1) begin
          state_n_s = ENM_ALIVE;
          cnt_n_s   = 8'd0;
        end else begin
          cnt_n_s = cnt_r - 8'd1;
        end
      end
      ENM_DEAD: begin
        hp_n_s  = 7'd0;
        cnt_n_s = 8'd0;
      end
      default: begin
        state_n_s = ENM_DEAD;
        hp_n_s    = 7'd0;
        cnt_n_s   = 8'd0;
      end
    endcase
  end

  // State, HP and counter registers
  always_ff @(posedge clk22) begin
    if (rst) begin
      state_r <= ENM_ALIVE;
      hp_r    <= HP_RST;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_n_s;
      hp_r    <= hp_n_s;
      cnt_r   <= cnt_n_s;
    end
  end

  assign hp    = hp_r;
  assign alive = (state_r != ENM_DEAD);
  assign flash = (state_r == ENM_IFRAME);
  assign dying = dying_s;

endmodule

// File: rtl/enm_hp_ctrl.sv
// Four-enemy HP controller: per-enemy units, kill counter and status decodes.
// Optional HP regeneration timer enabled by defining ENM_HP_REGEN_EN.
module enm_hp_ctrl
  import enm_pkg::*;
#(
  parameter int HP_INIT      = HP_INIT_DEF,
  parameter int IFRAMES      = IFRAMES_DEF,
  parameter int REGEN_PERIOD = REGEN_PERIOD_DEF
) (
  input  logic            clk22,
  input  logic            rst,
  input  logic [3:0]      hit,
  input  logic [2:0]      dmg,
  output logic [HP_W-1:0] enmhp1,
  output logic [HP_W-1:0] enmhp2,
  output logic [HP_W-1:0] enmhp3,
  output logic [HP_W-1:0] enmhp4,
  output logic [3:0]      alive,
  output logic [3:0]      flash,
  output logic            all_dead,
  output logic [7:0]      kill_cnt
);

  logic [HP_W-1:0] hp_s [4];
  logic [3:0]      alive_s;
  logic [3:0]      flash_s;
  logic [3:0]      dying_s;
  logic            regen_tick_s;
  logic [2:0]      kill_inc_s;
  logic [8:0]      kill_sum_s;
  logic [7:0]      kill_cnt_r;

`ifdef ENM_HP_REGEN_EN
  localparam logic [15:0] REGEN_LAST = 16'(REGEN_PERIOD - 1);
  logic [15:0] regen_tmr_r;

  assign regen_tick_s = (regen_tmr_r == REGEN_LAST);

  // Free-running regeneration timer, one tick per REGEN_PERIOD cycles
  always_ff @(posedge clk22) begin
    if (rst) begin
      regen_tmr_r <= 16'd0;
    end else if (regen_tick_s) begin
      regen_tmr_r <= 16'd0;
    end else begin
      regen_tmr_r <= regen_tmr_r + 16'd1;
    end
  end
`else
  assign regen_tick_s = 1'b0;
`endif

  for (genvar g = 0; g < 4; g++) begin : g_unit
    enm_hp_unit #(
      .HP_INIT (HP_INIT),
      .IFRAMES (IFRAMES)
    ) u_unit (
      .clk22      (clk22),
      .rst        (rst),
      .hit        (hit[g]),
      .dmg        (dmg),
      .regen_tick (regen_tick_s),
      .hp         (hp_s[g]),
      .alive      (alive_s[g]),
      .flash      (flash_s[g]),
      .dying      (dying_s[g])
    );
  end

  // Number of enemies entering DEAD this cycle, added with saturation
  always_comb begin
    kill_inc_s = 3'd0;
    for (int i = 0; i < 4; i++) begin
      kill_inc_s = kill_inc_s + {2'b00, dying_s[i]};
    end
    kill_sum_s = {1'b0, kill_cnt_r} + {6'd0, kill_inc_s};
  end

  // Kill counter register
  always_ff @(posedge clk22) begin
    if (rst) begin
      kill_cnt_r <= 8'd0;
    end else if (kill_sum_s[8]) begin
      kill_cnt_r <= 8'hFF;
    end else begin
      kill_cnt_r <= kill_sum_s[7:0];
    end
  end

  assign enmhp1   = hp_s[0];
  assign enmhp2   = hp_s[1];
  assign enmhp3   = hp_s[2];
  assign enmhp4   = hp_s[3];
  assign alive    = alive_s;
  assign flash    = flash_s;
  assign all_dead = (alive_s == 4'h0);
  assign kill_cnt = kill_cnt_r;

endmodule

// File: tb/tb_enm_hp_ctrl.sv
// Directed self-checking bench for enm_hp_ctrl with default parameters.
// Regeneration checks are built when ENM_HP_REGEN_EN is defined.
module tb_enm_hp_ctrl;

  logic       clk22 = 1'b0;
  logic       rst;
  logic [3:0] hit;
  logic [2:0] dmg;
  logic [6:0] enmhp1, enmhp2, enmhp3, enmhp4;
  logic [3:0] alive, flash;
  logic       all_dead;
  logic [7:0] kill_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int tcnt     = 0;

  enm_hp_ctrl dut (
    .clk22    (clk22),
    .rst      (rst),
    .hit      (hit),
    .dmg      (dmg),
    .enmhp1   (enmhp1),
    .enmhp2   (enmhp2),
    .enmhp3   (enmhp3),
    .enmhp4   (enmhp4),
    .alive    (alive),
    .flash    (flash),
    .all_dead (all_dead),
    .kill_cnt (kill_cnt)
  );

  always #5 clk22 = ~clk22;

  // Cycles since reset release, used to locate regeneration ticks
  always @(posedge clk22) begin
    if (rst) tcnt <= 0;
    else     tcnt <= tcnt + 1;
  end

  task automatic step();
    @(posedge clk22);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_hp(input string tag, input int exp);
    chk({tag, "_hp1"}, int'(enmhp1), exp);
    chk({tag, "_hp2"}, int'(enmhp2), exp);
    chk({tag, "_hp3"}, int'(enmhp3), exp);
    chk({tag, "_hp4"}, int'(enmhp4), exp);
  endtask

  // One-cycle hit, then wait out the 8-cycle IFRAME window
  task automatic hit_wait(input logic [3:0] m, input logic [2:0] d);
    hit = m;
    dmg = d;
    step();
    hit = 4'h0;
    dmg = 3'd0;
    repeat (8) step();
  endtask

  initial begin
    rst = 1'b1;
    hit = 4'h0;
    dmg = 3'd0;
    step();
    step();
    rst = 1'b0;

    chk_all_hp("reset", 100);
    chk("reset_alive", int'(alive), 15);
    chk("reset_flash", int'(flash), 0);
    chk("reset_all_dead", int'(all_dead), 0);
    chk("reset_kill", int'(kill_cnt), 0);

    // single hit on enemy 1, one-cycle latency, 8-cycle flash
    hit = 4'b0001;
    dmg = 3'd5;
    step();
    hit = 4'h0;
    dmg = 3'd0;
    chk("hit1_hp1", int'(enmhp1), 95);
    chk("hit1_hp2", int'(enmhp2), 100);
    chk("hit1_flash", int'(flash), 1);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("hit1_flash_hold", int'(flash), 1);
    end
    step();
    chk("hit1_flash_clear", int'(flash), 0);
    chk("hit1_hp1_after", int'(enmhp1), 95);

    // zero damage is ignored
    hit = 4'hF;
    dmg = 3'd0;
    step();
    hit = 4'h0;
    chk("dmg0_hp1", int'(enmhp1), 95);
    chk("dmg0_hp2", int'(enmhp2), 100);
    chk("dmg0_flash", int'(flash), 0);

    // held hit on enemy 2: one decrement per 9 cycles
    hit = 4'b0010;
    dmg = 3'd7;
    for (int n = 1; n <= 20; n++) begin
      step();
      chk("held_hp2", int'(enmhp2), 100 - 7 * ((n + 8) / 9));
    end
    hit = 4'h0;
    dmg = 3'd0;
    repeat (9) step();
    chk("held_hp2_final", int'(enmhp2), 79);
    chk("held_flash_clear", int'(flash), 0);

    // bring enemy 3 down to 3, then an overkill hit saturates to 0
    for (int i = 0; i < 13; i++) hit_wait(4'b0100, 3'd7);
    hit_wait(4'b0100, 3'd6);
    chk("e3_hp_3", int'(enmhp3), 3);
    hit = 4'b0100;
    dmg = 3'd7;
    step();
    hit = 4'h0;
    dmg = 3'd0;
    chk("e3_dead_hp", int'(enmhp3), 0);
    chk("e3_dead_alive", int'(alive), 11);
    chk("e3_dead_flash", int'(flash), 0);
    chk("e3_dead_kill", int'(kill_cnt), 1);
    hit_wait(4'b0100, 3'd7);
    chk("e3_dead_hold_hp", int'(enmhp3), 0);
    chk("e3_dead_hold_kill", int'(kill_cnt), 1);
    chk("e3_dead_hold_alive", int'(alive), 11);

    // kill enemy 4 as well
    for (int i = 0; i < 14; i++) hit_wait(4'b1000, 3'd7);
    chk("e4_hp_2", int'(enmhp4), 2);
    hit = 4'b1000;
    dmg = 3'd3;
    step();
    hit = 4'h0;
    dmg = 3'd0;
    chk("e4_dead_hp", int'(enmhp4), 0);
    chk("e4_dead_alive", int'(alive), 3);
    chk("e4_dead_kill", int'(kill_cnt), 2);
    chk("e4_all_dead", int'(all_dead), 0);

    // reset while enemy 1 is in IFRAME and two enemies are DEAD, with a hit pending
    hit = 4'b0001;
    dmg = 3'd1;
    step();
    chk("pre_rst_flash", int'(flash), 1);
    chk("pre_rst_hp1", int'(enmhp1), 94);
    rst = 1'b1;
    hit = 4'hF;
    dmg = 3'd7;
    step();
    rst = 1'b0;
    hit = 4'h0;
    dmg = 3'd0;
    chk_all_hp("rst_mid", 100);
    chk("rst_mid_alive", int'(alive), 15);
    chk("rst_mid_flash", int'(flash), 0);
    chk("rst_mid_kill", int'(kill_cnt), 0);
    chk("rst_mid_all_dead", int'(all_dead), 0);

    // all four to 2, then a simultaneous lethal hit
    for (int i = 0; i < 14; i++) hit_wait(4'hF, 3'd7);
    chk_all_hp("all2", 2);
    chk("all2_kill", int'(kill_cnt), 0);
    hit = 4'hF;
    dmg = 3'd4;
    step();
    hit = 4'h0;
    dmg = 3'd0;
    chk_all_hp("all_dead", 0);
    chk("all_dead_flag", int'(all_dead), 1);
    chk("all_dead_alive", int'(alive), 0);
    chk("all_dead_kill", int'(kill_cnt), 4);
    hit_wait(4'hF, 3'd7);
    chk("all_dead_kill_hold", int'(kill_cnt), 4);

    // reset out of DEAD
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_dead_hp1", int'(enmhp1), 100);
    chk("rst_dead_flag", int'(all_dead), 0);
    chk("rst_dead_kill", int'(kill_cnt), 0);

    hit_wait(4'b0001, 3'd5);
    chk("regen_base_hp1", int'(enmhp1), 95);
`ifdef ENM_HP_REGEN_EN
    repeat (128) step();
    chk("regen_128_hp1", int'(enmhp1), 97);
    for (int i = 0; i < 64; i++) begin
      if ((tcnt % 64) == 63) break;
      step();
    end
    chk("regen_tick_found", tcnt % 64, 63);
    hit = 4'b0001;
    dmg = 3'd1;
    step();
    hit = 4'h0;
    dmg = 3'd0;
    chk("regen_hit_wins", int'(enmhp1), 96);
`else
    repeat (200) step();
    chk("no_regen_hp1", int'(enmhp1), 95);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
